// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, requester
// limits, FSM state encoding and the round-robin pointer advance helper.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int MAX_REQ     = 8;
  localparam int REQ_ID_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_t;

  // Index following idx, wrapping from n_req-1 back to 0.
  function automatic logic [REQ_ID_W-1:0] rr_next(input logic [REQ_ID_W-1:0] idx,
                                                  input int n_req);
    if (int'(idx) >= n_req - 1) begin
      return {REQ_ID_W{1'b0}};
    end else begin
      return idx + 3'd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of valid at or after ptr,
// wrapping at N_REQ-1; found is low when no bit is set.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]    valid,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic [REQ_ID_W-1:0] idx,
  output logic                found
);

  logic [N_REQ-1:0] rot_s;
  int               sum_s;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    rot_s = N_REQ'({valid, valid} >> ptr);
    idx   = {REQ_ID_W{1'b0}};
    found = 1'b0;
    sum_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot_s[k]) begin
        found = 1'b1;
        sum_s = int'(ptr) + k;
        if (sum_s >= N_REQ) begin
          sum_s = sum_s - N_REQ;
        end else begin
          sum_s = sum_s;
        end
        idx = REQ_ID_W'(sum_s);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// Per-requester saturating byte counters exist only when UART_TX_ARB_STATS_EN is defined.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             req_ack,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [REQ_ID_W-1:0]          grant_id,
  output logic                         arb_busy,
  output logic [CNT_W*N_REQ-1:0]       stat_cnt
);

  arb_state_t             state_r;
  logic [REQ_ID_W-1:0]    rr_ptr_r;
  logic [N_REQ-1:0]       req_ack_r;
  logic [UART_BYTE_W-1:0] tx_data_r;
  logic                   tx_start_r;
  logic [REQ_ID_W-1:0]    grant_id_r;
  logic                   arb_busy_r;

  logic [REQ_ID_W-1:0]    pick_idx_s;
  logic                   pick_found_s;
  logic [UART_BYTE_W-1:0] pick_byte_s;
  logic [N_REQ-1:0]       pick_onehot_s;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Byte and one-hot ack of the requester chosen by the selector.
  always_comb begin
    pick_byte_s   = {UART_BYTE_W{1'b0}};
    pick_onehot_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx_s == REQ_ID_W'(i)) begin
        pick_byte_s      = req_data[UART_BYTE_W*i +: UART_BYTE_W];
        pick_onehot_s[i] = 1'b1;
      end else begin
        pick_onehot_s[i] = 1'b0;
      end
    end
  end

  // Arbiter FSM; ack, data and start pulse all register on the LOAD decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= {REQ_ID_W{1'b0}};
      req_ack_r  <= {N_REQ{1'b0}};
      tx_data_r  <= {UART_BYTE_W{1'b0}};
      tx_start_r <= 1'b0;
      grant_id_r <= {REQ_ID_W{1'b0}};
      arb_busy_r <= 1'b0;
    end else begin
      req_ack_r  <= {N_REQ{1'b0}};
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            state_r    <= ST_LOAD;
            arb_busy_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Requests may have been withdrawn since IDLE; re-pick from what remains.
          if (pick_found_s) begin
            tx_data_r  <= pick_byte_s;
            grant_id_r <= pick_idx_s;
            req_ack_r  <= pick_onehot_s;
            rr_ptr_r   <= rr_next(pick_idx_s, N_REQ);
            tx_start_r <= 1'b1;
            state_r    <= ST_START;
          end else begin
            state_r    <= ST_IDLE;
            arb_busy_r <= 1'b0;
          end
        end
        ST_START: state_r <= ST_HOLD;
        ST_HOLD:  state_r <= ST_DRAIN;
        ST_DRAIN: begin
          if (!tx_busy) begin
            state_r    <= ST_IDLE;
            arb_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          arb_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack  = req_ack_r;
  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign grant_id = grant_id_r;
  assign arb_busy = arb_busy_r;

`ifdef UART_TX_ARB_STATS_EN
  logic [CNT_W*N_REQ-1:0] stat_cnt_r;

  // Saturating count of acknowledged bytes per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_r <= {(CNT_W*N_REQ){1'b0}};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ack_r[i] && (stat_cnt_r[CNT_W*i +: CNT_W] != {CNT_W{1'b1}})) begin
          stat_cnt_r[CNT_W*i +: CNT_W] <= stat_cnt_r[CNT_W*i +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign stat_cnt = stat_cnt_r;
`else
  assign stat_cnt = {(CNT_W*N_REQ){1'b0}};
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed vector table, multi-cycle corner
// sequences and a randomized phase checked against a round-robin grant model.
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_ack;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            arb_busy;
  logic [CW*N-1:0] stat_cnt;

  uart_tx_arb #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .stat_cnt  (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   m_ptr;
  int   m_stat [N];
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  // Reference round-robin choice: first valid index at or after the model pointer.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int e);
    logic [N-1:0] r;
    r = '0;
    if (e >= 0 && e < N) r[e] = 1'b1;
    return r;
  endfunction

  task automatic note_grant(input int id);
    m_ptr = (id + 1) % N;
    if (m_stat[id] < (1 << CW) - 1) m_stat[id]++;
  endtask

  task automatic model_reset;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  task automatic chk_stats(input string tag);
    int e;
    for (int i = 0; i < N; i++) begin
`ifdef UART_TX_ARB_STATS_EN
      e = m_stat[i];
`else
      e = 0;
`endif
      chk($sformatf("%s_stat%0d", tag, i), 32'(stat_cnt[CW*i +: CW]), 32'(e));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"},   32'(req_ack),  32'd0);
    chk({tag, "_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_data"},  32'(tx_data),  32'd0);
    chk({tag, "_gid"},   32'(grant_id), 32'd0);
    chk({tag, "_busy"},  32'(arb_busy), 32'd0);
    chk({tag, "_stat"},  32'(stat_cnt), 32'd0);
  endtask

  task automatic do_reset;
    tick;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_ack(input int bound, output int lat);
    lat = 0;
    do begin
      tick;
      lat++;
    end while (req_ack == '0 && lat < bound);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (arb_busy && n < 200);
    chk({tag, "_idle"}, 32'(arb_busy), 32'd0);
  endtask

  // One request from IDLE: ack two cycles later with the expected grant.
  task automatic one_shot(input string tag, input logic [3:0] v, input logic [31:0] d,
                          input int exp_id, input logic [7:0] exp_byte);
    int lat;
    req_valid = v;
    req_data  = d;
    wait_ack(20, lat);
    chk({tag, "_lat"},   32'(lat),      32'd2);
    chk({tag, "_ack"},   32'(req_ack),  32'(onehot(exp_id)));
    chk({tag, "_gid"},   32'(grant_id), 32'(exp_id));
    chk({tag, "_data"},  32'(tx_data),  32'(exp_byte));
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    note_grant(exp_id);
    req_valid = '0;
    wait_idle(tag);
  endtask

  initial begin
    int          lat, bad_cyc, e, granted, busy_left, last_start, grants;
    int          wait_g [N];
    logic [7:0]  cur_byte [N];
    int          rot_id [5];
    logic [7:0]  rot_byte [5];

    tbl[0] = '{4'b0001, 32'h44434241, 0, 8'h41};
    tbl[1] = '{4'b0001, 32'h14131211, 0, 8'h11};
    tbl[2] = '{4'b1001, 32'h24232221, 3, 8'h24};
    tbl[3] = '{4'b0110, 32'h34333231, 1, 8'h32};
    tbl[4] = '{4'b0110, 32'h54535251, 2, 8'h53};
    tbl[5] = '{4'b0110, 32'h64636261, 1, 8'h62};
    tbl[6] = '{4'b1111, 32'h74737271, 2, 8'h73};
    tbl[7] = '{4'b1000, 32'h84838281, 3, 8'h84};
    tbl[8] = '{4'b0100, 32'h94939291, 2, 8'h93};
    tbl[9] = '{4'b0011, 32'hA4A3A2A1, 0, 8'hA1};
    rot_id   = '{0, 1, 2, 3, 0};
    rot_byte = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    do_reset();
    chk_zero_outputs("reset");

    // Directed table; the pointer carries over from row to row.
    for (int r = 0; r < 10; r++) begin
      one_shot($sformatf("tbl%0d", r), tbl[r].valid, tbl[r].data, tbl[r].exp_id, tbl[r].exp_byte);
    end
    chk_stats("tbl");

    // All requesters continuously valid: grants rotate 0,1,2,3,0.
    do_reset();
    req_valid  = 4'b1111;
    req_data   = 32'h40302010;
    last_start = 0;
    for (int r = 0; r < 5; r++) begin
      wait_ack(20, lat);
      chk($sformatf("rot%0d_gid", r),  32'(grant_id), 32'(rot_id[r]));
      chk($sformatf("rot%0d_data", r), 32'(tx_data),  32'(rot_byte[r]));
      chk($sformatf("rot%0d_ack", r),  32'(req_ack),  32'(onehot(rot_id[r])));
      if (r > 0) chk($sformatf("rot%0d_spacing", r), 32'(cyc - last_start >= 5), 32'd1);
      last_start = cyc;
      note_grant(rot_id[r]);
    end
    req_valid = '0;
    wait_idle("rot");

    // Transmitter busy for 100 cycles: nothing new until busy falls.
    req_valid = 4'b0010;
    req_data  = 32'h00005A00;
    wait_ack(20, lat);
    chk("busy_first_gid",  32'(grant_id), 32'd1);
    chk("busy_first_data", 32'(tx_data),  32'h5A);
    note_grant(1);
    req_valid = 4'b1000;
    req_data  = 32'hC3000000;
    tx_busy   = 1'b1;
    bad_cyc   = 0;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (req_ack != '0 || tx_start) bad_cyc++;
    end
    chk("busy_hold_quiet", 32'(bad_cyc), 32'd0);
    tx_busy = 1'b0;
    wait_ack(20, lat);
    chk("busy_release_lat", 32'(lat),      32'd3);
    chk("busy_release_gid", 32'(grant_id), 32'd3);
    chk("busy_release_data", 32'(tx_data), 32'hC3);
    note_grant(3);
    req_valid = '0;
    wait_idle("busy");

    // One-cycle request pulse in IDLE: withdrawn before LOAD, no grant.
    req_valid = 4'b0100;
    req_data  = 32'h00770000;
    tick;
    chk("pulse_load_busy", 32'(arb_busy), 32'd1);
    req_valid = '0;
    bad_cyc   = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (req_ack != '0 || tx_start) bad_cyc++;
    end
    chk("pulse_no_grant", 32'(bad_cyc),  32'd0);
    chk("pulse_idle",     32'(arb_busy), 32'd0);

    // Reset while draining, then a normal request from a reset pointer.
    req_valid = 4'b0010;
    req_data  = 32'h00006600;
    wait_ack(20, lat);
    chk("drain_gid", 32'(grant_id), 32'd1);
    note_grant(1);
    req_valid = '0;
    tx_busy   = 1'b1;
    tick; tick; tick;
    chk("drain_busy", 32'(arb_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    model_reset();
    tick;
    rst_n   = 1'b1;
    tx_busy = 1'b0;
    one_shot("post_rst", 4'b0110, 32'h00998800, 1, 8'h88);

    // Twenty bytes from requester 1: 4-bit counter saturates.
    for (int r = 0; r < 20; r++) begin
      one_shot($sformatf("sat%0d", r), 4'b0010, {16'h0000, 8'(r + 1), 8'h00}, 1, 8'(r + 1));
    end
`ifdef UART_TX_ARB_STATS_EN
    chk("sat_slice1", 32'(stat_cnt[CW*1 +: CW]), 32'hF);
`else
    chk("sat_slice1", 32'(stat_cnt[CW*1 +: CW]), 32'h0);
`endif
    chk_stats("sat");

    // Randomized traffic against the round-robin model.
    req_valid = '0;
    tx_busy   = 1'b0;
    busy_left = 0;
    last_start = -1;
    grants    = 0;
    for (int i = 0; i < N; i++) begin
      wait_g[i]   = 0;
      cur_byte[i] = 8'h00;
    end
    for (int c = 0; c < 3000; c++) begin
      tick;
      granted = -1;
      if (req_ack != '0 || tx_start) begin
        e = model_pick(req_valid);
        chk("rnd_ack",   32'(req_ack),  32'(onehot(e)));
        chk("rnd_start", 32'(tx_start), 32'd1);
        if (e >= 0) begin
          chk("rnd_gid",  32'(grant_id), 32'(e));
          chk("rnd_data", 32'(tx_data),  32'(cur_byte[e]));
          chk("rnd_fair", 32'(wait_g[e] <= N - 1), 32'd1);
          if (last_start >= 0) chk("rnd_spacing", 32'(cyc - last_start >= 5), 32'd1);
          last_start = cyc;
          for (int i = 0; i < N; i++) if (req_valid[i] && i != e) wait_g[i]++;
          wait_g[e]    = 0;
          req_valid[e] = 1'b0;
          note_grant(e);
          grants++;
          granted   = e;
          busy_left = $urandom_range(0, 6);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && i != granted && $urandom_range(0, 2) == 0) begin
          cur_byte[i]          = 8'($urandom);
          req_data[8*i +: 8]   = cur_byte[i];
          req_valid[i]         = 1'b1;
          wait_g[i]            = 0;
        end
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    req_valid = '0;
    tx_busy   = 1'b0;
    wait_idle("rnd");
    chk("rnd_grant_count", 32'(grants > 100), 32'd1);
    chk_stats("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
